// File: rtl/alu_result_checker.sv
// Response checker for ALU result streams: compares each accepted beat with its
// expectation, counts mismatches, records the first failure and folds results into a MISR.
module alu_result_checker #(
   parameter int unsigned NUM_VECTORS = 8,
   parameter logic [31:0] SIG_SEED    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  af,
   input  logic [31:0] Alures,
   input  logic        Zero,
   input  logic        Neg,
   input  logic        ovfalu,
   input  logic [31:0] exp_res,
   input  logic [2:0]  exp_flags,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] first_err_idx,
   output logic [3:0]  first_err_af,
   output logic [31:0] signature
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

   state_t      state_q, state_d;
   logic [15:0] err_q, err_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] first_idx_q, first_idx_d;
   logic [3:0]  first_af_q, first_af_d;
   logic [31:0] sig_q, sig_d;

   logic        accept;
   logic        mismatch;
   logic        fb;
   logic [31:0] misr_in;

   // Handshake: a beat transfers only when in_valid and in_ready are both high
   // on a rising edge; a beat coinciding with start is dropped.
   assign in_ready = (state_q == S_RUN);
   assign accept   = in_ready & in_valid & ~start;

   // Overflow is only meaningful for the add function code.
   assign mismatch = (Alures != exp_res) | (Zero != exp_flags[2]) | (Neg != exp_flags[1])
                   | ((af == 4'b0000) & (ovfalu != exp_flags[0]));

   assign misr_in = Alures ^ {Zero, Neg, ovfalu, 29'b0};
   assign fb      = sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0];

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      idx_d       = idx_q;
      first_idx_d = first_idx_q;
      first_af_d  = first_af_q;
      sig_d       = sig_q;
      if (start) begin
         state_d     = S_RUN;
         err_d       = 16'h0000;
         idx_d       = 16'h0000;
         first_idx_d = 16'h0000;
         first_af_d  = 4'h0;
         sig_d       = SIG_SEED;
      end else if (accept) begin
         sig_d = {sig_q[30:0], fb} ^ misr_in;
         idx_d = idx_q + 16'h0001;
         if (mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'h0001;
            if (err_q == 16'h0000) begin
               first_idx_d = idx_q;
               first_af_d  = af;
            end
         end
         if (idx_q == LAST_IDX) state_d = S_DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         err_q       <= 16'h0000;
         idx_q       <= 16'h0000;
         first_idx_q <= 16'h0000;
         first_af_q  <= 4'h0;
         sig_q       <= SIG_SEED;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         idx_q       <= idx_d;
         first_idx_q <= first_idx_d;
         first_af_q  <= first_af_d;
         sig_q       <= sig_d;
      end
   end

   assign busy          = (state_q == S_RUN);
   assign done          = (state_q == S_DONE);
   assign pass          = done & (err_q == 16'h0000);
   assign err_count     = err_q;
   assign first_err_idx = first_idx_q;
   assign first_err_af  = first_af_q;
   assign signature     = sig_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: one instance with a single-beat run,
// one with an eight-beat run and a non-zero seed.
module tb_alu_result_checker;

   localparam logic [31:0] SEED8 = 32'hA5A5_0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0, start8 = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  af = 4'h0;
   logic [31:0] alures = 32'h0, exp_res = 32'h0;
   logic        zero = 1'b0, neg = 1'b0, ovf = 1'b0;
   logic [2:0]  exp_flags = 3'b000;

   logic        in_ready1, busy1, done1, pass1;
   logic [15:0] err1, fidx1;
   logic [3:0]  faf1;
   logic [31:0] sig1;
   logic        in_ready8, busy8, done8, pass8;
   logic [15:0] err8, fidx8;
   logic [3:0]  faf8;
   logic [31:0] sig8;

   int total = 0;
   int bad = 0;
   int acc8 = 0;
   int acc_base;
   logic [34:0] exp_q[$];
   logic [31:0] res_t[8];
   logic [31:0] exp_t[8];

   always #5 clk = ~clk;

   alu_result_checker #(.NUM_VECTORS(1), .SIG_SEED(32'h0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
      .af(af), .Alures(alures), .Zero(zero), .Neg(neg), .ovfalu(ovf),
      .exp_res(exp_res), .exp_flags(exp_flags), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_err_idx(fidx1), .first_err_af(faf1), .signature(sig1));

   alu_result_checker #(.NUM_VECTORS(8), .SIG_SEED(SEED8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(in_valid), .in_ready(in_ready8),
      .af(af), .Alures(alures), .Zero(zero), .Neg(neg), .ovfalu(ovf),
      .exp_res(exp_res), .exp_flags(exp_flags), .busy(busy8), .done(done8), .pass(pass8),
      .err_count(err8), .first_err_idx(fidx8), .first_err_af(faf8), .signature(sig8));

   always @(posedge clk) begin
      if (in_valid && in_ready8 && !start8) acc8 <= acc8 + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [34:0] b);
      logic [31:0] d;
      logic        f;
      d = b[31:0] ^ {b[34:32], 29'b0};
      f = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], f} ^ d;
   endfunction

   function automatic logic [31:0] sig_of_q(input logic [31:0] seed);
      logic [31:0] s;
      s = seed;
      foreach (exp_q[i]) s = misr_step(s, exp_q[i]);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start8();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
   endtask

   task automatic send_beat(input logic [3:0] a, input logic [31:0] r, input logic z,
                            input logic n, input logic o, input logic [31:0] er,
                            input logic [2:0] ef, input bit record);
      af = a; alures = r; zero = z; neg = n; ovf = o; exp_res = er; exp_flags = ef;
      in_valid = 1'b1;
      if (record) exp_q.push_back({z, n, o, r});
      tick();
      in_valid = 1'b0;
   endtask

   // Eight immediate-op results; variant 1 corrupts the expectations of beats 3 and 6.
   task automatic run_stream(input bit variant);
      logic [31:0] er;
      logic        n;
      for (int i = 0; i < 8; i++) begin
         er = exp_t[i];
         if (variant && i == 3) er = 32'd2;
         if (variant && i == 6) er = 32'd0;
         n = res_t[i][31];
         send_beat(4'(i), res_t[i], 1'b0, n, 1'b0, er, {1'b0, n, 1'b0}, 1'b1);
         if (i == 6) check_val("done_before_last", 32'(done8), 32'd0);
         if (i == 7) check_val("done_after_last", 32'(done8), 32'd1);
         tick();
      end
   endtask

   initial begin
      res_t = '{32'd30, 32'd50, 32'd1, 32'd1, 32'd1, 32'd10, 32'd14, 32'hFFFF_0000};
      exp_t = '{32'd30, 32'd50, 32'd1, 32'd1, 32'd1, 32'd10, 32'd14, 32'hFFFF_0000};

      // Reset values
      #12;
      check_val("rst_ready", 32'(in_ready8), 32'd0);
      check_val("rst_busy", 32'(busy8), 32'd0);
      check_val("rst_done", 32'(done8), 32'd0);
      check_val("rst_pass", 32'(pass8), 32'd0);
      check_val("rst_err", 32'(err8), 32'd0);
      check_val("rst_sig8", sig8, SEED8);
      check_val("rst_sig1", sig1, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Single-beat run
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check_val("t1_busy", 32'(busy1), 32'd1);
      check_val("t1_ready", 32'(in_ready1), 32'd1);
      send_beat(4'h0, 32'd30, 1'b0, 1'b0, 1'b0, 32'd30, 3'b000, 1'b0);
      check_val("t1_sig", sig1, 32'h0000_001E);
      check_val("t1_err", 32'(err1), 32'd0);
      check_val("t1_done", 32'(done1), 32'd1);
      check_val("t1_pass", 32'(pass1), 32'd1);
      check_val("t1_ready_after", 32'(in_ready1), 32'd0);
      check_val("t1_idle8", 32'(err8), 32'd0);

      // Clean eight-op stream with toggled valid
      pulse_start8();
      exp_q.delete();
      acc_base = acc8;
      run_stream(1'b0);
      check_val("t2_accepts", 32'(acc8 - acc_base), 32'd8);
      check_val("t2_pass", 32'(pass8), 32'd1);
      check_val("t2_err", 32'(err8), 32'd0);
      check_val("t2_sig", sig8, sig_of_q(SEED8));
      send_beat(4'h0, 32'd7, 1'b0, 1'b0, 1'b0, 32'd8, 3'b000, 1'b0);
      check_val("t2_done_ignores", 32'(err8), 32'd0);
      check_val("t2_done_accepts", 32'(acc8 - acc_base), 32'd8);
      check_val("t2_done_sig", sig8, sig_of_q(SEED8));

      // Same stream with two corrupted expectations
      pulse_start8();
      check_val("t3_cleared_done", 32'(done8), 32'd0);
      exp_q.delete();
      run_stream(1'b1);
      check_val("t3_err", 32'(err8), 32'd2);
      check_val("t3_fidx", 32'(fidx8), 32'd3);
      check_val("t3_faf", 32'(faf8), 32'h3);
      check_val("t3_pass", 32'(pass8), 32'd0);
      check_val("t3_sig", sig8, sig_of_q(SEED8));

      // Overflow only compared for af=0000
      pulse_start8();
      send_beat(4'h4, 32'd5, 1'b0, 1'b0, 1'b1, 32'd5, 3'b000, 1'b0);
      check_val("t4_ovf_ignored", 32'(err8), 32'd0);
      send_beat(4'h0, 32'd5, 1'b0, 1'b0, 1'b1, 32'd5, 3'b000, 1'b0);
      check_val("t4_ovf_err", 32'(err8), 32'd1);
      check_val("t4_fidx", 32'(fidx8), 32'd1);
      check_val("t4_faf", 32'(faf8), 32'h0);

      // Abort mid-run with a beat presented alongside start
      pulse_start8();
      for (int i = 0; i < 4; i++)
         send_beat(4'(i), 32'd9, 1'b0, 1'b0, 1'b0, (i == 1) ? 32'd8 : 32'd9, 3'b000, 1'b0);
      check_val("t5_pre_err", 32'(err8), 32'd1);
      af = 4'h2; alures = 32'd3; exp_res = 32'd4; exp_flags = 3'b000;
      zero = 1'b0; neg = 1'b0; ovf = 1'b0;
      start8 = 1'b1;
      in_valid = 1'b1;
      tick();
      start8 = 1'b0;
      in_valid = 1'b0;
      check_val("t5_err_clear", 32'(err8), 32'd0);
      check_val("t5_fidx_clear", 32'(fidx8), 32'd0);
      check_val("t5_sig_reseed", sig8, SEED8);
      check_val("t5_busy", 32'(busy8), 32'd1);
      exp_q.delete();
      run_stream(1'b0);
      check_val("t5_pass", 32'(pass8), 32'd1);
      check_val("t5_sig", sig8, sig_of_q(SEED8));

      // Asynchronous reset mid-run
      pulse_start8();
      for (int i = 0; i < 3; i++)
         send_beat(4'h1, 32'd11, 1'b0, 1'b0, 1'b0, 32'd12, 3'b000, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_ready", 32'(in_ready8), 32'd0);
      check_val("t6_busy", 32'(busy8), 32'd0);
      check_val("t6_err", 32'(err8), 32'd0);
      check_val("t6_fidx", 32'(fidx8), 32'd0);
      check_val("t6_faf", 32'(faf8), 32'd0);
      check_val("t6_sig", sig8, SEED8);
      check_val("t6_done1", 32'(done1), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_beat(4'h0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd2, 3'b000, 1'b0);
      tick();
      check_val("t6_ready_hold", 32'(in_ready8), 32'd0);
      check_val("t6_err_hold", 32'(err8), 32'd0);
      check_val("t6_sig_hold", sig8, SEED8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Synthesizable response checker that sits on the output side of the ALU. It consumes a stream of ALU results (Alures, Zero, Neg, ovfalu) paired with expected values, counts mismatches, records the first failure, and compresses all results into a 32-bit MISR signature. It is used for on-chip ALU self-test and as the bench-side scoreboard for ALU stimulus sequences.

Parameters:
NUM_VECTORS, 8, number of result beats accepted per run (1..65535).
SIG_SEED, 32'h0000_0000, MISR value loaded on start.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; begins a new run.
in_valid  input  1  result beat valid.
in_ready  output  1  checker can accept a beat.
af  input  4  ALU function code of the beat.
Alures  input  32  ALU result.
Zero  input  1  ALU zero flag.
Neg  input  1  ALU negative flag.
ovfalu  input  1  ALU overflow flag.
exp_res  input  32  expected result.
exp_flags  input  3  expected {Zero,Neg,ovfalu}.
busy  output  1  run in progress.
done  output  1  run complete (level, held until next start).
pass  output  1  done and err_count==0.
err_count  output  16  mismatch count, saturating.
first_err_idx  output  16  beat index of first mismatch.
first_err_af  output  4  af of first mismatch.
signature  output  32  MISR state.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_af=0, signature=SIG_SEED, internal beat index idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=0. start=1 moves to RUN next cycle and clears err_count, idx, first_err_*, done, and pass; loads signature=SIG_SEED.
- RUN: busy=1, in_ready=1. A beat is accepted when in_valid && in_ready. in_valid without in_ready is ignored, so no beat is accepted in IDLE or DONE.
- Per accepted beat, all updates are registered and visible the next cycle:
  - Mismatch = (Alures!=exp_res) | (Zero!=exp_flags[2]) | (Neg!=exp_flags[1]) | ((af==4'b0000) & (ovfalu!=exp_flags[0])). ovfalu is compared only for af=0000; for every other af it is ignored.
  - On mismatch, err_count increments and saturates at 16'hFFFF. If err_count was 0 before the beat, first_err_idx=idx and first_err_af=af are captured.
  - MISR: D = Alures ^ {Zero,Neg,ovfalu,29'b0}; fb = sig[31]^sig[21]^sig[1]^sig[0]; sig_next = {sig[30:0],fb} ^ D.
  - idx increments. On the beat where idx==NUM_VECTORS-1, the FSM goes to DONE next cycle.
- DONE: busy=0, in_ready=0, done=1, pass=(err_count==0). All results hold until the next start.
- start while in RUN aborts the run. It behaves exactly as start from IDLE: clear, reseed, stay in RUN. A beat accepted in the same cycle as start is discarded.
- start in DONE begins a new run (DONE to RUN).
- Reset mid-run returns to reset values immediately. No partial results are retained.
- Latency: 1 cycle from accept to updated counters and signature. Throughput is 1 beat per cycle.

Test Plan:
- SIG_SEED=0, NUM_VECTORS=1. start, then one beat Alures=30, exp_res=30, flags 000/000, af=0000 -> signature=32'h0000_001E, err_count=0, done=1, pass=1 one cycle after accept.
- NUM_VECTORS=8. Drive the eight ALU ops (addi 10+20=30, addiu 30+20=50, slti 5<10 gives 1, sltiu gives 1, andi 15&1=1, ori 8|2=10, xori 15^1=14, lui 0000FFFF<<16=FFFF0000) with correct expectations and in_valid toggled 1/0 -> exactly 8 accepts, done asserts 1 cycle after the 8th accept, pass=1.
- Same stream with beat 3 exp_res=2 instead of 1 and beat 6 exp_res=0 -> err_count=2, first_err_idx=3, first_err_af=4'b0011, pass=0.
- Beat af=0100 with ovfalu=1, exp_flags[0]=0 -> no mismatch. Same mismatch with af=0000 -> err_count=1.
- start pulsed mid-run after 4 beats, with in_valid=1 in the start cycle -> err_count, idx, and signature reseeded, and that beat is not counted. Then 8 more beats -> done.
- rst_n asserted low for 1 cycle mid-run -> all outputs equal reset values asynchronously. in_ready=0 until the next start.
